// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive engine.
// Contents: oversample/tick constants, receiver state encoding, status flag payload.
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = 4;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned LAST_TICK  = 15;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_e;

  // Error flags travelling with each received byte
  typedef struct packed {
    logic frame_err;
    logic parity_err;
  } rx_flags_t;

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver.
// master: receiver drives rx_data/rx_valid/flags/rx_overrun/rx_busy, samples rx_ready.
// slave : consumer samples the byte and status, drives rx_ready.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;
  logic                 rx_busy;

  modport master (
    output rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to 1 (idle-high lines).
// Ports: clk, rstb (sync, active-high), d (async in), q (synchronised out).
module uart_rx_sync_2ff (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rstb) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: 16x oversampled, LSB-first, optional parity, one-byte
// output register with valid/ready handshake and sticky overrun.
// Ports: clk, rstb (sync, active-high), rx_clk_en (16x baud tick),
//        rxd (async serial in, idle high), bus (uart_rx_if.master).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     rstb,
  input  logic     rx_clk_en,
  input  logic     rxd,
  uart_rx_if.master bus
);

  logic                 rxd_s;
  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 busy_q;
  logic                 load_c;
  logic                 ferr_c;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  rx_flags_t            flags_q;
  logic                 ovr_q;
  logic                 xfer_c;

  uart_rx_sync_2ff u_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (rxd),
    .q    (rxd_s)
  );

  // Frame FSM state, counters and shift register
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state logic; everything advances only on oversample ticks
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    load_c  = 1'b0;
    ferr_c  = 1'b0;
    if (rx_clk_en) begin
      tick_d = tick_q + TICK_W'(1);
      unique case (state_q)
        IDLE: begin
          tick_d = '0;
          if (!rxd_s) state_d = START;
        end
        START: begin
          if (tick_q == TICK_W'(MID_TICK)) begin
            tick_d  = '0;
            bit_d   = '0;
            perr_d  = 1'b0;
            state_d = rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_q == TICK_W'(LAST_TICK)) begin
            // Line is LSB first: shift in from the top
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_CNT_W'(1);
            if (bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick_q == TICK_W'(LAST_TICK)) begin
            perr_d  = ((^shift_q) ^ rxd_s) != (PARITY_ODD != 0);
            state_d = STOP;
          end
        end
        STOP: begin
          if (tick_q == TICK_W'(LAST_TICK)) begin
            load_c  = 1'b1;
            ferr_c  = !rxd_s;
            state_d = rxd_s ? IDLE : BRK_WAIT;
          end
        end
        BRK_WAIT: begin
          // Hold off new starts until the line returns high after a break
          if (rxd_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign xfer_c = valid_q && bus.rx_ready;

  // Output holding register with handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (rstb) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      flags_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (load_c && (!valid_q || bus.rx_ready)) begin
        data_q             <= shift_q;
        valid_q            <= 1'b1;
        flags_q.frame_err  <= ferr_c;
        flags_q.parity_err <= (PARITY_EN != 0) && perr_q;
      end else if (xfer_c) begin
        valid_q <= 1'b0;
      end
      if (xfer_c) begin
        ovr_q <= 1'b0;
      end else if (load_c && valid_q) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign bus.rx_data       = data_q;
  assign bus.rx_valid      = valid_q;
  assign bus.rx_frame_err  = flags_q.frame_err;
  assign bus.rx_parity_err = flags_q.parity_err;
  assign bus.rx_overrun    = ovr_q;
  assign bus.rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8O1 instance, frames driven at
// 64 clk per bit, expected bytes queued at issue and checked by monitors.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CLK_PER_TICK = 4;
  localparam int BIT_CLKS     = OVERSAMPLE * CLK_PER_TICK;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;
  logic rx_clk_en;
  logic rxd0, rxd1;
  logic rdy0_man, rdy1_man, rdy_rand, rand_en;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   total = 0;
  int   bad   = 0;
  int   vcnt0 = 0;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_if #(.DATA_BITS(8)) bus1 ();

  assign bus0.rx_ready = rand_en ? rdy_rand : rdy0_man;
  assign bus1.rx_ready = rand_en ? rdy_rand : rdy1_man;

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk       (clk),
    .rstb      (rstb),
    .rx_clk_en (rx_clk_en),
    .rxd       (rxd0),
    .bus       (bus0.master)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
    .clk       (clk),
    .rstb      (rstb),
    .rx_clk_en (rx_clk_en),
    .rxd       (rxd1),
    .bus       (bus1.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: byte as sent, frame error if stop was 0, parity error by count of ones
  function automatic exp_t model(input logic [7:0] d, input bit par_en, input bit par_odd,
                                 input bit par_bit, input bit stop_bit);
    exp_t m;
    int   ones;
    ones   = $countones(d) + int'(par_bit);
    m.data = d;
    m.ferr = !stop_bit;
    m.perr = par_en ? (((ones % 2) == 1) != par_odd) : 1'b0;
    return m;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) rxd0 = b;
    else          rxd1 = b;
  endtask

  // Leaves the line at the stop-bit level; caller returns it to idle
  task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                            input bit par_bit, input bit stop_bit);
    drive(sel, 1'b0);
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      wait_clk(BIT_CLKS);
    end
    if (par_en) begin
      drive(sel, par_bit);
      wait_clk(BIT_CLKS);
    end
    drive(sel, stop_bit);
    wait_clk(BIT_CLKS);
  endtask

  task automatic issue(input int sel, input logic [7:0] d, input bit par_bit, input bit stop_bit);
    if (sel == 0) q0.push_back(model(d, 1'b0, 1'b0, par_bit, stop_bit));
    else          q1.push_back(model(d, 1'b1, 1'b1, par_bit, stop_bit));
    send_frame(sel, d, sel != 0, par_bit, stop_bit);
  endtask

  // 16x baud tick: one clk in every four
  initial begin
    rx_clk_en = 1'b0;
    forever begin
      for (int k = 0; k < CLK_PER_TICK; k++) begin
        @(posedge clk);
        #1;
        rx_clk_en = (k == CLK_PER_TICK - 1);
      end
    end
  end

  initial begin
    rdy_rand = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rdy_rand = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (bus0.rx_valid === 1'b1) vcnt0++;
    if (bus0.rx_valid === 1'b1 && bus0.rx_ready === 1'b1) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut0_unexpected_byte actual=%02h required=no byte (t=%0t)", bus0.rx_data, $time);
      end else begin
        e0 = q0.pop_front();
        check("dut0_data", 32'(bus0.rx_data), 32'(e0.data));
        check("dut0_frame_err", 32'(bus0.rx_frame_err), 32'(e0.ferr));
        check("dut0_parity_err", 32'(bus0.rx_parity_err), 32'(e0.perr));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.rx_valid === 1'b1 && bus1.rx_ready === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1_unexpected_byte actual=%02h required=no byte (t=%0t)", bus1.rx_data, $time);
      end else begin
        e1 = q1.pop_front();
        check("dut1_data", 32'(bus1.rx_data), 32'(e1.data));
        check("dut1_frame_err", 32'(bus1.rx_frame_err), 32'(e1.ferr));
        check("dut1_parity_err", 32'(bus1.rx_parity_err), 32'(e1.perr));
      end
    end
  end

  initial begin
    int         v;
    logic [7:0] d;
    bit         p, s;

    rstb = 1'b1;
    rxd0 = 1'b1;
    rxd1 = 1'b1;
    rdy0_man = 1'b0;
    rdy1_man = 1'b0;
    rand_en  = 1'b0;
    wait_clk(5);

    check("rst_data", 32'(bus0.rx_data), 32'h0);
    check("rst_valid", 32'(bus0.rx_valid), 32'h0);
    check("rst_frame_err", 32'(bus0.rx_frame_err), 32'h0);
    check("rst_parity_err", 32'(bus0.rx_parity_err), 32'h0);
    check("rst_overrun", 32'(bus0.rx_overrun), 32'h0);
    check("rst_busy", 32'(bus0.rx_busy), 32'h0);
    check("rst_dut1_valid", 32'(bus1.rx_valid), 32'h0);
    check("rst_dut1_busy", 32'(bus1.rx_busy), 32'h0);

    rstb = 1'b0;
    wait_clk(20);

    // Single 0x55 frame, consumer always ready
    rdy0_man = 1'b1;
    v = vcnt0;
    issue(0, 8'h55, 1'b0, 1'b1);
    drive(0, 1'b1);
    wait_clk(BIT_CLKS);
    check("t55_valid_cycles", 32'(vcnt0 - v), 32'd1);
    check("t55_overrun", 32'(bus0.rx_overrun), 32'h0);

    // Back-to-back frames with consumer stalled: second frame dropped
    rdy0_man = 1'b0;
    issue(0, 8'hA5, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1);
    wait_clk(32);
    check("ovr_valid", 32'(bus0.rx_valid), 32'h1);
    check("ovr_data_kept", 32'(bus0.rx_data), 32'hA5);
    check("ovr_overrun", 32'(bus0.rx_overrun), 32'h1);
    rdy0_man = 1'b1;
    wait_clk(1);
    rdy0_man = 1'b0;
    check("ovr_valid_after_xfer", 32'(bus0.rx_valid), 32'h0);
    check("ovr_overrun_after_xfer", 32'(bus0.rx_overrun), 32'h0);
    rdy0_man = 1'b1;
    wait_clk(BIT_CLKS);

    // Start-bit glitch of 4 ticks
    drive(0, 1'b0);
    wait_clk(12);
    check("glitch_busy", 32'(bus0.rx_busy), 32'h1);
    wait_clk(4);
    drive(0, 1'b1);
    wait_clk(2 * BIT_CLKS);
    check("glitch_idle", 32'(bus0.rx_busy), 32'h0);
    check("glitch_valid", 32'(bus0.rx_valid), 32'h0);

    // Break: stop bit 0 then line held low for 40 ticks
    issue(0, 8'h81, 1'b0, 1'b0);
    wait_clk(40 * CLK_PER_TICK);
    check("brk_busy", 32'(bus0.rx_busy), 32'h1);
    check("brk_valid", 32'(bus0.rx_valid), 32'h0);
    drive(0, 1'b1);
    wait_clk(BIT_CLKS);
    check("brk_released", 32'(bus0.rx_busy), 32'h0);

    // Odd parity on the parity instance
    rdy1_man = 1'b1;
    issue(1, 8'h07, 1'b1, 1'b1);
    drive(1, 1'b1);
    wait_clk(BIT_CLKS);
    issue(1, 8'h07, 1'b0, 1'b1);
    drive(1, 1'b1);
    wait_clk(BIT_CLKS);

    // Reset in the middle of data bit 3
    d = 8'hB6;
    drive(0, 1'b0);
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      drive(0, d[i]);
      wait_clk(BIT_CLKS);
    end
    drive(0, d[3]);
    wait_clk(32);
    check("midrst_busy_before", 32'(bus0.rx_busy), 32'h1);
    rstb = 1'b1;
    wait_clk(1);
    check("midrst_busy", 32'(bus0.rx_busy), 32'h0);
    check("midrst_valid", 32'(bus0.rx_valid), 32'h0);
    rstb = 1'b0;
    drive(0, 1'b1);
    wait_clk(4 * BIT_CLKS);
    issue(0, 8'h42, 1'b0, 1'b1);
    drive(0, 1'b1);
    wait_clk(BIT_CLKS);

    // Randomised frames with a randomly stalling consumer
    rand_en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      issue(0, d, 1'b0, s);
      drive(0, 1'b1);
      wait_clk(BIT_CLKS);
    end
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      issue(1, d, p, 1'b1);
      drive(1, 1'b1);
      wait_clk(BIT_CLKS);
    end
    rand_en  = 1'b0;
    rdy0_man = 1'b1;
    rdy1_man = 1'b1;
    wait_clk(200);

    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);
    check("final_overrun", 32'(bus0.rx_overrun), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
